// File: rtl/dz_pkg.sv
// Shared constants, state encoding and helpers for the egg-hatch display scheduler.
package dz_pkg;

  localparam logic [3:0] IMG_ANIMAL_BASE = 4'd8;
  localparam logic [3:0] IMG_BLANK       = 4'd12;
  localparam logic [3:0] IMG_FAIL        = 4'd13;

  localparam logic COLOR_RED   = 1'b0;
  localparam logic COLOR_GREEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    REQ,
    WAIT_RAND,
    REVEAL,
    FAIL_ON,
    FAIL_OFF,
    DONE
  } dz_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dz_tick_timer.sv
// Tick-gated up-counter; o_done flags the tick that completes i_limit ticks.
// The owner clears it on every phase change, so it never wraps.
module dz_tick_timer #(
  parameter int MAX_LIMIT = 16,
  localparam int W = $clog2(MAX_LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_tick,
  input  logic [W-1:0] i_limit,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_tick) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_done = i_en && i_tick && (r_cnt == i_limit - W'(1));

endmodule

// File: rtl/dz_scheduler.sv
// Display scheduler: arbitrates hatch progress, animal reveal and fail blink onto
// one registered image code with a load strobe; fail preempts everything but DONE.
module dz_scheduler
  import dz_pkg::*;
#(
  parameter int HOLD_TICKS   = 8,
  parameter int BLINK_TICKS  = 4,
  parameter int BLINK_COUNT  = 3,
  parameter int RAND_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] progress,
  input  logic       progress_vld,
  input  logic       fail,
  input  logic [4:0] rand_val,
  input  logic       rand_vld,
  output logic       rand_st,
  output logic [3:0] img_code,
  output logic       img_load,
  output logic       color,
  output logic       busy
);

  localparam int TMAX = max3(HOLD_TICKS, BLINK_TICKS, RAND_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BLINK_COUNT + 1);

  dz_state_e     r_state;
  dz_state_e     w_state_nxt;
  logic [3:0]    r_img_code;
  logic [3:0]    w_code_nxt;
  logic          r_color;
  logic          w_color_nxt;
  logic          r_img_load;
  logic          w_load_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_nxt;

  logic          w_tmr_en;
  logic          w_tmr_clr;
  logic          w_tmr_done;
  logic [TW-1:0] w_limit;
  logic          w_fail_take;
  logic          w_unused;

  assign w_unused = ^rand_val[4:2];

  // Timer setup depends only on the registered state, keeping done free of comb loops.
  assign w_tmr_en = (r_state == WAIT_RAND) || (r_state == REVEAL) ||
                    (r_state == FAIL_ON)   || (r_state == FAIL_OFF);

  always_comb begin
    w_limit = TW'(BLINK_TICKS);
    case (r_state)
      WAIT_RAND: w_limit = TW'(RAND_TIMEOUT);
      REVEAL:    w_limit = TW'(HOLD_TICKS);
      default:   w_limit = TW'(BLINK_TICKS);
    endcase
  end

  assign w_fail_take = fail && (r_state != FAIL_ON) && (r_state != FAIL_OFF) &&
                       (r_state != DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_img_code;
    w_color_nxt = r_color;
    w_load_nxt  = 1'b0;
    w_blink_nxt = r_blink_cnt;
    if (w_fail_take) begin
      w_state_nxt = FAIL_ON;
      w_code_nxt  = IMG_FAIL;
      w_color_nxt = COLOR_GREEN;
      w_load_nxt  = 1'b1;
      w_blink_nxt = '0;
    end else begin
      case (r_state)
        IDLE, SHOW: begin
          if (progress_vld && (progress < 5'd16)) begin
            w_state_nxt = SHOW;
            w_code_nxt  = {1'b0, progress[3:1]};
            w_color_nxt = COLOR_RED;
            w_load_nxt  = 1'b1;
          end else if (progress_vld && (progress == 5'd16)) begin
            w_state_nxt = REQ;
          end
        end
        REQ: w_state_nxt = WAIT_RAND;
        WAIT_RAND: begin
          if (rand_vld || w_tmr_done) begin
            w_state_nxt = REVEAL;
            w_code_nxt  = rand_vld ? (IMG_ANIMAL_BASE + {2'b00, rand_val[1:0]})
                                   : IMG_ANIMAL_BASE;
            w_color_nxt = COLOR_RED;
            w_load_nxt  = 1'b1;
          end
        end
        REVEAL: begin
          if (w_tmr_done) begin
            w_state_nxt = IDLE;
            w_code_nxt  = IMG_BLANK;
            w_load_nxt  = 1'b1;
          end
        end
        FAIL_ON: begin
          if (w_tmr_done) begin
            w_state_nxt = FAIL_OFF;
            w_code_nxt  = IMG_BLANK;
            w_load_nxt  = 1'b1;
          end
        end
        FAIL_OFF: begin
          if (w_tmr_done) begin
            w_code_nxt = IMG_FAIL;
            w_load_nxt = 1'b1;
            if (r_blink_cnt == BW'(BLINK_COUNT - 1)) begin
              w_state_nxt = DONE;
              w_blink_nxt = '0;
            end else begin
              w_state_nxt = FAIL_ON;
              w_blink_nxt = r_blink_cnt + BW'(1);
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Any phase change restarts the shared timer, so the entry cycle's tick never counts.
  assign w_tmr_clr = (w_state_nxt != r_state);

  dz_tick_timer #(
    .MAX_LIMIT(TMAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_tick  (tick),
    .i_limit (w_limit),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_img_code  <= IMG_BLANK;
      r_color     <= COLOR_RED;
      r_img_load  <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_img_code  <= w_code_nxt;
      r_color     <= w_color_nxt;
      r_img_load  <= w_load_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

  assign img_code = r_img_code;
  assign color    = r_color;
  assign img_load = r_img_load;
  assign rand_st  = (r_state == REQ);
  assign busy     = (r_state == REQ) || (r_state == WAIT_RAND) || (r_state == REVEAL) ||
                    (r_state == FAIL_ON) || (r_state == FAIL_OFF);

endmodule

// File: tb/tb_dz_scheduler.sv
// Scoreboard bench for dz_scheduler: stimulus queues expected image loads and
// random requests; a negedge monitor pops and compares whenever the DUT strobes.
module tb_dz_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] progress;
  logic       progress_vld;
  logic       fail;
  logic [4:0] rand_val;
  logic       rand_vld;
  logic       rand_st;
  logic [3:0] img_code;
  logic       img_load;
  logic       color;
  logic       busy;

  typedef struct {
    logic [3:0] code;
    logic       color;
  } exp_t;

  exp_t img_q[$];
  int   rs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t mon_e;
  int   mon_c;

  dz_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .progress     (progress),
    .progress_vld (progress_vld),
    .fail         (fail),
    .rand_val     (rand_val),
    .rand_vld     (rand_vld),
    .rand_st      (rand_st),
    .img_code     (img_code),
    .img_load     (img_load),
    .color        (color),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (img_load) begin
        checks++;
        if (img_q.size() == 0) begin
          errors++;
          $display("FAIL img_load unexpected: code=%0d color=%0d cycle=%0d", img_code, color, cyc);
        end else begin
          mon_e = img_q.pop_front();
          if (img_code !== mon_e.code || color !== mon_e.color) begin
            errors++;
            $display("FAIL img_load value: got code=%0d color=%0d, expected code=%0d color=%0d",
                     img_code, color, mon_e.code, mon_e.color);
          end
        end
      end
      if (rand_st) begin
        checks++;
        if (rs_q.size() == 0) begin
          errors++;
          $display("FAIL rand_st unexpected at cycle %0d", cyc);
        end else begin
          mon_c = rs_q.pop_front();
          if (cyc != mon_c) begin
            errors++;
            $display("FAIL rand_st timing: got cycle %0d, expected cycle %0d", cyc, mon_c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_img(input logic [3:0] c, input logic col);
    exp_t e;
    e.code  = c;
    e.color = col;
    img_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic prog(input logic [4:0] v);
    progress     = v;
    progress_vld = 1'b1;
    step();
    progress_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; progress = '0; progress_vld = 1'b0;
    fail = 1'b0; rand_val = '0; rand_vld = 1'b0;
    idle(2);
    chk("reset img_code", 32'(img_code), 12);
    chk("reset img_load", 32'(img_load), 0);
    chk("reset color", 32'(color), 0);
    chk("reset rand_st", 32'(rand_st), 0);
    chk("reset busy", 32'(busy), 0);
    rst = 1'b0;
    idle(1);

    // Progress frames, including an unchanged code and an out-of-range value.
    push_img(4'd3, 1'b0); prog(5'd6);  idle(1);
    push_img(4'd3, 1'b0); prog(5'd7);  idle(1);
    push_img(4'd7, 1'b0); prog(5'd15); idle(1);
    prog(5'd20); idle(1);
    chk("busy in SHOW", 32'(busy), 0);

    // Hatch with random answer 2'b10 -> animal 10, then hold of 8 ticks.
    rs_q.push_back(cyc + 1); prog(5'd16);
    idle(2);
    chk("busy in WAIT_RAND", 32'(busy), 1);
    push_img(4'd10, 1'b0);
    rand_val = 5'b10110; rand_vld = 1'b1; step(); rand_vld = 1'b0;
    ticks(7);
    push_img(4'd12, 1'b0);
    ticks(1);
    chk("busy after reveal", 32'(busy), 0);

    // Hatch with no answer: timeout falls back to animal 8; late answer ignored.
    rs_q.push_back(cyc + 1); prog(5'd16);
    idle(2);
    ticks(15);
    push_img(4'd8, 1'b0);
    ticks(1);
    rand_val = 5'd3; rand_vld = 1'b1; step(); rand_vld = 1'b0;
    ticks(7);
    push_img(4'd12, 1'b0);
    ticks(1);

    // Fail from SHOW: three blink pairs then steady fail in DONE.
    push_img(4'd2, 1'b0); prog(5'd4); idle(1);
    push_img(4'd13, 1'b1);
    fail = 1'b1; step(); fail = 1'b0;
    chk("busy in FAIL_ON", 32'(busy), 1);
    for (int p = 0; p < 3; p++) begin
      ticks(3); push_img(4'd12, 1'b1); ticks(1);
      ticks(3); push_img(4'd13, 1'b1); ticks(1);
    end
    chk("busy in DONE", 32'(busy), 0);
    prog(5'd5);
    fail = 1'b1; step(); fail = 1'b0;
    ticks(10);
    chk("DONE img_code", 32'(img_code), 13);
    chk("DONE busy", 32'(busy), 0);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Fail and rand_vld together in WAIT_RAND: fail wins; then async reset mid FAIL_OFF.
    rs_q.push_back(cyc + 1); prog(5'd16);
    idle(2);
    push_img(4'd13, 1'b1);
    rand_val = 5'd1; rand_vld = 1'b1; fail = 1'b1; step();
    rand_vld = 1'b0; fail = 1'b0;
    ticks(3); push_img(4'd12, 1'b1); ticks(1);
    ticks(2);
    #2 rst = 1'b1;
    #1;
    chk("async rst img_code", 32'(img_code), 12);
    chk("async rst img_load", 32'(img_load), 0);
    chk("async rst color", 32'(color), 0);
    chk("async rst rand_st", 32'(rand_st), 0);
    chk("async rst busy", 32'(busy), 0);
    step(); rst = 1'b0; step();
    push_img(4'd2, 1'b0); prog(5'd4);
    idle(3);

    chk("img queue drained", 32'(img_q.size()), 0);
    chk("rand_st queue drained", 32'(rs_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dz_scheduler.md
# dz_scheduler

Display scheduler for the 8x8 dual-colour dot matrix in the egg-hatch game. It arbitrates three image sources: hatch-progress frames, the random-animal reveal and the fail blink sequence. It drives one image code plus a load strobe into the matrix transfer/scan stage, and owns the start/valid handshake with the random-number generator.

## Interface
Parameters:
- HOLD_TICKS, 8: frame ticks the revealed animal stays on before returning to blank
- BLINK_TICKS, 4: frame ticks per fail on-phase and per off-phase
- BLINK_COUNT, 3: number of fail on/off pairs before the steady fail image
- RAND_TIMEOUT, 16: frame ticks spent waiting for rand_vld before falling back to animal 0

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle frame-rate enable; all timers count only on tick
- progress  in  5  hatch progress 0..16; value 16 means hatched
- progress_vld  in  1  one-cycle strobe qualifying progress
- fail  in  1  level; game lost
- rand_val  in  5  random value; only bits [1:0] are used
- rand_vld  in  1  one-cycle strobe qualifying rand_val
- rand_st  out  1  one-cycle request to the random generator
- img_code  out  4  image select: 0..7 progress frames, 8..11 animals, 12 blank, 13 fail
- img_load  out  1  one-cycle strobe; img_code is valid and changed this cycle
- color  out  1  0 = red, 1 = green
- busy  out  1  high in REQ, WAIT_RAND, REVEAL, FAIL_ON and FAIL_OFF

## Operation
- States: IDLE, SHOW, REQ, WAIT_RAND, REVEAL, FAIL_ON, FAIL_OFF, DONE.
- Reset values: state IDLE, img_code 12, img_load 0, color 0, rand_st 0, busy 0, all counters 0.
- Fail has top priority. In any state except FAIL_ON, FAIL_OFF and DONE, fail = 1 does the following:
  - next state is FAIL_ON; img_code 13, color 1, img_load pulses
  - blink and tick counters clear
- Progress, in IDLE or SHOW with progress_vld and progress < 16:
  - state goes to SHOW; img_code = progress >> 1; color 0; img_load pulses
  - img_load pulses even when the code is unchanged
- Hatch, in IDLE or SHOW with progress_vld and progress == 16:
  - state goes to REQ, which holds for one cycle with rand_st = 1, then WAIT_RAND
  - progress_vld values of 17..31 are ignored in every state
- WAIT_RAND:
  - On rand_vld: go to REVEAL; img_code = 8 + rand_val[1:0]; color 0; img_load pulses.
  - If RAND_TIMEOUT ticks pass with no rand_vld: the same action with code 8.
- REVEAL: after HOLD_TICKS ticks, go to IDLE; img_code 12; img_load pulses.
- progress_vld is ignored in REQ, WAIT_RAND and REVEAL. rand_vld is ignored outside WAIT_RAND.
- FAIL_ON: after BLINK_TICKS ticks, go to FAIL_OFF; img_code 12; img_load pulses.
- FAIL_OFF: after BLINK_TICKS ticks, increment blink_cnt.
  - If blink_cnt reaches BLINK_COUNT: go to DONE; img_code 13; img_load pulses; busy 0.
  - Otherwise: go to FAIL_ON; img_code 13; img_load pulses.
- DONE is absorbing. Only rst leaves it; fail and progress are ignored.
- Counter widths are sized by $clog2(max parameter + 1). Counters never wrap: each clears on the transition that consumes it.

## Timing
- Input-to-output latency is 1 clock. img_code, color and img_load are registered and update together on the edge after the triggering input is sampled.
- img_code and color hold between img_load strobes.
- A tick that completes a timer causes the transition on that same edge.
- N ticks in a phase means the transition happens on the Nth tick after phase entry. The entry cycle's tick does not count.
- rand_st is high for exactly one cycle: the cycle after the progress == 16 strobe is sampled. The generator may answer with rand_vld no earlier than the cycle after rand_st.
- Simultaneous events, fail wins over each of:
  - progress_vld, in IDLE or SHOW
  - rand_vld, in WAIT_RAND
  - the REVEAL hold expiring
- Reset asserted mid-sequence returns all outputs to their reset values immediately (asynchronous). Any pending random request is abandoned.

## Structure
- Shared package dz_pkg holds:
  - image code constants: IMG_ANIMAL_BASE = 8, IMG_BLANK = 12, IMG_FAIL = 13
  - COLOR_RED and COLOR_GREEN
  - the state enum
- One sub-module, dz_tick_timer: a tick-gated up-counter with clear input and terminal-count output, parameterised by its limit. It is instantiated once and reloaded per phase.

## Test plan
- progress_vld with progress = 6, then 7, then 15 -> img_code 3, 3, 7, each with a one-cycle img_load; color 0; busy 0.
- progress = 16 -> rand_st one cycle later. Then rand_vld with rand_val = 5'b10110 -> img_code 10 with img_load; after 8 ticks, img_code 12 with img_load; busy drops.
- progress = 16 and no rand_vld for 16 ticks -> img_code 8 with img_load. A later rand_vld is ignored.
- fail in SHOW -> img_code 13, color 1. Then the code sequence 13 / 12 alternates every 4 ticks for 3 pairs, ending at steady 13 in DONE with busy 0. A later progress_vld is ignored.
- fail and rand_vld in the same cycle during WAIT_RAND -> FAIL_ON with img_code 13; no animal code is ever emitted.
- rst asserted mid-FAIL_OFF, asynchronously between edges -> outputs are immediately 12 / 0 / 0 / 0 / 0; a progress = 4 strobe afterwards yields img_code 2.
